// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf
//   ID/EX pipeline stage with a valid/ready handshake on both sides and a
//   two-entry buffer (main + skid). Decode results are captured here and
//   presented to execute. The stage supports backpressure, stall and flush,
//   and counts bubble cycles for performance visibility.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   flush                           drop every held entry (mispredict / trap)
//   in_valid / in_ready             upstream handshake, transfer = in_valid & in_ready
//   pc_in, rdata1_in, rdata2_in,
//   imm_in, rs1_in, rs2_in, rd_in,
//   funct_in, wb_in, m_in, ex_in    payload from decode
//   out_valid / out_ready           downstream handshake, pop = out_valid & out_ready
//   pc_out .. ex_out                registered payload to execute
//                                   (ex_out[1:0] = ALUOp, ex_out[2] = ALUSrc)
//   bubble_cnt                      saturating count of cycles with out_valid = 0
module id_ex_stage_buf #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REGW   = 5,
  parameter int unsigned FUNCTW = 4,
  parameter int unsigned WBW    = 2,
  parameter int unsigned MW     = 3,
  parameter int unsigned EXW    = 3,
  parameter int unsigned CNTW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   rdata1_in,
  input  logic [XLEN-1:0]   rdata2_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [REGW-1:0]   rs1_in,
  input  logic [REGW-1:0]   rs2_in,
  input  logic [REGW-1:0]   rd_in,
  input  logic [FUNCTW-1:0] funct_in,
  input  logic [WBW-1:0]    wb_in,
  input  logic [MW-1:0]     m_in,
  input  logic [EXW-1:0]    ex_in,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rdata1_out,
  output logic [XLEN-1:0]   rdata2_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REGW-1:0]   rs1_out,
  output logic [REGW-1:0]   rs2_out,
  output logic [REGW-1:0]   rd_out,
  output logic [FUNCTW-1:0] funct_out,
  output logic [WBW-1:0]    wb_out,
  output logic [MW-1:0]     m_out,
  output logic [EXW-1:0]    ex_out,

  output logic [CNTW-1:0]   bubble_cnt
);

  // Control bundles sit in the low bits of the packed payload so they can be
  // masked as one slice when the stage presents a bubble.
  localparam int unsigned CTLW = WBW + MW + EXW;
  localparam int unsigned DATW = 4 * XLEN + 3 * REGW + FUNCTW;
  localparam int unsigned PLW  = DATW + CTLW;

  logic [PLW-1:0]  w_in_pl;
  logic            w_xfer;
  logic            w_pop;
  logic            w_cnt_sat;
  logic [CNTW-1:0] w_cnt_inc;

  logic [PLW-1:0]  r_main_pl;
  logic [PLW-1:0]  r_skid_pl;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic [CNTW-1:0] r_bubble_cnt;

  assign w_in_pl = {pc_in, rdata1_in, rdata2_in, imm_in, rs1_in, rs2_in, rd_in, funct_in,
                    wb_in, m_in, ex_in};

  // Ready depends only on stored state (and reset), never on out_ready, so no
  // combinational path runs from execute back into decode.
  assign in_ready = ~r_skid_valid & ~reset;
  assign w_xfer   = in_valid & in_ready;
  assign w_pop    = r_main_valid & out_ready;

  assign w_cnt_sat = &r_bubble_cnt;
  assign w_cnt_inc = r_bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_pl    <= '0;
      r_skid_pl    <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (!r_main_valid && !w_cnt_sat) begin
        r_bubble_cnt <= w_cnt_inc;
      end

      if (flush) begin
        // An entry popped this cycle has already been taken by execute; a
        // transfer arriving this cycle belongs to the wrong path and is dropped.
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_pop) begin
        if (r_skid_valid) begin
          // Older skid entry always advances ahead of any newer input.
          r_main_pl    <= r_skid_pl;
          r_main_valid <= 1'b1;
          r_skid_valid <= w_xfer;
          if (w_xfer) begin
            r_skid_pl <= w_in_pl;
          end
        end else if (w_xfer) begin
          r_main_pl    <= w_in_pl;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_xfer) begin
        r_skid_pl    <= w_in_pl;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid  = r_main_valid;
  assign bubble_cnt = r_bubble_cnt;

  // Data fields keep their last value during a bubble; control reads as a NOP.
  assign {pc_out, rdata1_out, rdata2_out, imm_out, rs1_out, rs2_out, rd_out, funct_out} =
         r_main_pl[PLW-1:CTLW];
  assign {wb_out, m_out, ex_out} = r_main_valid ? r_main_pl[CTLW-1:0] : {CTLW{1'b0}};

endmodule

// File: tb/tb_id_ex_stage_buf.sv
module tb_id_ex_stage_buf;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REGW   = 5;
  localparam int unsigned FUNCTW = 4;
  localparam int unsigned WBW    = 2;
  localparam int unsigned MW     = 3;
  localparam int unsigned EXW    = 3;
  localparam int unsigned CTLW   = WBW + MW + EXW;
  localparam int unsigned PLW    = 4 * XLEN + 3 * REGW + FUNCTW + CTLW;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc_in, rdata1_in, rdata2_in, imm_in;
  logic [REGW-1:0]   rs1_in, rs2_in, rd_in;
  logic [FUNCTW-1:0] funct_in;
  logic [WBW-1:0]    wb_in;
  logic [MW-1:0]     m_in;
  logic [EXW-1:0]    ex_in;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_out, rdata1_out, rdata2_out, imm_out;
  logic [REGW-1:0]   rs1_out, rs2_out, rd_out;
  logic [FUNCTW-1:0] funct_out;
  logic [WBW-1:0]    wb_out;
  logic [MW-1:0]     m_out;
  logic [EXW-1:0]    ex_out;
  logic [31:0]       bubble_cnt;

  // Second instance with a 3-bit counter to exercise saturation.
  logic              d3_in_ready, d3_out_valid;
  logic [XLEN-1:0]   d3_pc_out, d3_rdata1_out, d3_rdata2_out, d3_imm_out;
  logic [REGW-1:0]   d3_rs1_out, d3_rs2_out, d3_rd_out;
  logic [FUNCTW-1:0] d3_funct_out;
  logic [WBW-1:0]    d3_wb_out;
  logic [MW-1:0]     d3_m_out;
  logic [EXW-1:0]    d3_ex_out;
  logic [2:0]        d3_bubble_cnt;

  logic [PLW-1:0] in_pl, out_pl;
  assign in_pl  = {pc_in, rdata1_in, rdata2_in, imm_in, rs1_in, rs2_in, rd_in, funct_in,
                   wb_in, m_in, ex_in};
  assign out_pl = {pc_out, rdata1_out, rdata2_out, imm_out, rs1_out, rs2_out, rd_out,
                   funct_out, wb_out, m_out, ex_out};

  id_ex_stage_buf #(.XLEN(XLEN), .REGW(REGW), .FUNCTW(FUNCTW), .WBW(WBW), .MW(MW), .EXW(EXW),
                    .CNTW(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .funct_in(funct_in),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .funct_out(funct_out),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_buf #(.XLEN(XLEN), .REGW(REGW), .FUNCTW(FUNCTW), .WBW(WBW), .MW(MW), .EXW(EXW),
                    .CNTW(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d3_in_ready),
    .pc_in(pc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .funct_in(funct_in),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .out_valid(d3_out_valid), .out_ready(out_ready),
    .pc_out(d3_pc_out), .rdata1_out(d3_rdata1_out), .rdata2_out(d3_rdata2_out),
    .imm_out(d3_imm_out), .rs1_out(d3_rs1_out), .rs2_out(d3_rs2_out), .rd_out(d3_rd_out),
    .funct_out(d3_funct_out), .wb_out(d3_wb_out), .m_out(d3_m_out), .ex_out(d3_ex_out),
    .bubble_cnt(d3_bubble_cnt)
  );

  // Reference model: the stage is a FIFO of at most two accepted, not yet
  // consumed instructions; a flush or reset empties it.
  logic [PLW-1:0] q[$];
  logic [31:0]    exp_bub;
  logic [2:0]     exp_bub3;
  bit             started;
  int             n_chk;
  int             n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks state visible after the last edge, then consumes on pop.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (started) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, !reset && q.size() < 2);
        chk("bubble_cnt", bubble_cnt, exp_bub);
        chk("bubble_cnt_w3", d3_bubble_cnt, exp_bub3);
        chk("out_valid_w3", d3_out_valid, q.size() > 0);
        if (!out_valid) chk("ctl_nop", {wb_out, m_out, ex_out}, '0);
        if (!reset && q.size() == 0) begin
          if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 32'd1;
          if (exp_bub3 != 3'd7) exp_bub3 = exp_bub3 + 3'd1;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_underflow: got pc %h expected no output", pc_out);
          end else begin
            chk("payload", out_pl, q.pop_front());
          end
        end
      end
    end
  end

  // Drives one cycle of stimulus, then records what the upcoming edge does.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy,
                      input logic [XLEN-1:0] pc);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    pc_in     = pc;
    rdata1_in = {$urandom, $urandom};
    rdata2_in = {$urandom, $urandom};
    imm_in    = {$urandom, $urandom};
    rs1_in    = REGW'($urandom);
    rs2_in    = REGW'($urandom);
    rd_in     = REGW'($urandom);
    funct_in  = FUNCTW'($urandom);
    wb_in     = WBW'($urandom);
    m_in      = MW'($urandom);
    ex_in     = EXW'($urandom);
    #2;
    if (rst) begin
      q.delete();
      exp_bub  = '0;
      exp_bub3 = '0;
    end else if (fl) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      q.push_back(in_pl);
    end
    started = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; rdata1_in = '0; rdata2_in = '0; imm_in = '0;
    rs1_in = '0; rs2_in = '0; rd_in = '0; funct_in = '0;
    wb_in = '0; m_in = '0; ex_in = '0;
    exp_bub = '0; exp_bub3 = '0; started = 1'b0; n_chk = 0; n_fail = 0;

    // Reset, then idle cycles for bubble counting and saturation.
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      #1;
      if (i == 1) begin
        chk("reset_payload", out_pl, '0);
        chk("reset_bubble", bubble_cnt, 32'd0);
      end
      if (i == 6) chk("bubble_5", bubble_cnt, 32'd5);
      if (i == 11) begin
        chk("bubble_10", bubble_cnt, 32'd10);
        chk("bubble_sat_w3", d3_bubble_cnt, 3'd7);
      end
    end

    // Streaming.
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h8);
    #1;
    chk("stream_pc", pc_out, 64'h4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Backpressure: A in main, B in skid, C held off.
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hA0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hB0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hC0);
    #1;
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_hold_pc", pc_out, 64'hA0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hC0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i < 2, 1'b1, 64'hC0);

    // Flush with a full stage and a simultaneous transfer attempt.
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h104);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h108);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_ctl", {wb_out, m_out, ex_out}, '0);
    // Flush while empty but a transfer is offered: it must be dropped.
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h10C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    #1;
    chk("flush_xfer_drop", out_valid, 1'b0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 999) < 2, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
           {$urandom, $urandom});
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    #1;
    chk("drain_empty", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
